axi_read_slv: RTL and testbench
===============================

AXI_READ_SLV -- requirements
Module: axi_read_slv

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, the AR/R ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, the byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, the R data width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-005 SHALL provide the AR channel: ARID in ID_WIDTH; ARADDR in ADDR_WIDTH; ARLEN in 8; ARSIZE in 3; ARBURST in 2; ARVALID in 1; ARREADY out 1.
REQ-006 SHALL provide the R channel: RID out ID_WIDTH; RDATA out DATA_WIDTH; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1.
REQ-007 SHALL provide the memory port: mem_rd_en out 1 (read strobe); mem_rd_addr out ADDR_WIDTH (byte address, low 3 bits zero); mem_rd_data in DATA_WIDTH (valid the cycle after mem_rd_en).

Function
REQ-008 SHALL implement FSM states IDLE, REQ, CAP, RESP.
- IDLE->REQ on an AR handshake (ARVALID & ARREADY).
- REQ->CAP always.
- CAP->RESP always.
- RESP->REQ on an R handshake when the beat is not last.
- RESP->IDLE on an R handshake of the last beat when no burst is queued.
REQ-009 SHALL latch ARID, ARADDR, ARLEN, ARSIZE and ARBURST on the AR handshake.
REQ-010 SHALL drive mem_rd_en=1 in REQ only, with mem_rd_addr = current beat address with bits [2:0] forced to 0.
REQ-011 SHALL register mem_rd_data into RDATA at the end of CAP.
REQ-012 SHALL assert RVALID only in RESP, and hold RID, RDATA, RRESP and RLAST stable until RREADY is sampled high.
REQ-013 SHALL give a first-beat latency of 3 cycles: AR handshake in cycle N, RVALID high in cycle N+3, and 3 cycles per subsequent beat with RREADY tied high.
REQ-014 SHALL emit exactly ARLEN+1 beats, using an 8-bit beat counter, and assert RLAST on beat ARLEN only.
REQ-015 SHALL compute the next beat address modulo 2^ADDR_WIDTH, by burst type:
- FIXED (00): unchanged.
- INCR (01): addr + (1<<ARSIZE).
- WRAP (10): wraps inside the (ARLEN+1)*(1<<ARSIZE)-byte aligned boundary.
REQ-016 SHALL treat a burst with ARBURST=11, or ARSIZE>3, or WRAP with ARLEN not in {1,3,7,15}, as an error burst:
- RRESP=2'b10 (SLVERR) on all ARLEN+1 beats.
- RDATA all zeros.
- mem_rd_en held at 0.
- Same timing as a normal burst.
REQ-017 SHALL return RRESP=2'b00 (OKAY) for all non-error bursts.
REQ-018 SHALL echo the latched ARID on RID for every beat of a burst.

Reset
REQ-019 SHALL, while rst_n=0, force:
- FSM=IDLE;
- RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0;
- mem_rd_en=0, mem_rd_addr=0;
- ARREADY=0;
- beat counter and queue empty.
REQ-020 SHALL drive ARREADY=1 from the first clock edge after rst_n rises.
REQ-021 SHALL abandon an in-flight burst on reset assertion with no further R beats.

Configuration
REQ-022 SHALL use the macro AXI_READ_SLV_OUTSTAND_EN:
- Defined: a 2-entry AR queue is compiled in; ARREADY = queue not full in any state; on the last-beat handshake with the queue non-empty, the FSM goes RESP->REQ with the head entry and no idle cycle.
- Undefined: ARREADY=1 only in IDLE.
REQ-023 SHALL, when AXI_READ_SLV_OUTSTAND_EN is defined, return queued bursts in acceptance order, and handle a simultaneous AR accept and queue pop in one cycle without loss.

Verification
REQ-024 SHALL cover single beat: ARADDR=0x010, ARLEN=0, ARSIZE=3, INCR, ARID=5 -> mem_rd_addr=0x010; one beat with RID=5, RLAST=1, RRESP=00, RVALID at N+3.
REQ-025 SHALL cover INCR burst: ARADDR=0x3F8, ARLEN=3, ARSIZE=3 -> addresses 0x3F8, 0x000, 0x008, 0x010; RLAST on the 4th beat only.
REQ-026 SHALL cover WRAP burst: ARADDR=0x018, ARLEN=3, ARSIZE=3 -> addresses 0x018, 0x000, 0x008, 0x010.
REQ-027 SHALL cover error burst: ARBURST=11, ARLEN=1 -> two beats with RRESP=10 and RDATA=0; mem_rd_en never high.
REQ-028 SHALL cover backpressure and reset: RREADY low 5 cycles in beat 1 -> RDATA/RID stable and no extra mem_rd_en; rst_n pulsed mid-burst -> RVALID=0 and IDLE.
REQ-029 SHALL cover back-to-back bursts (macro defined): two ARs accepted in consecutive cycles -> second burst's first mem_rd_en in the cycle after the first burst's last R handshake.

Source files
------------

// File: rtl/axi_read_slv.sv
// axi_read_slv: AXI4 read slave, one beat per 3 cycles against a 1-cycle-latency memory.
// Define AXI_READ_SLV_OUTSTAND_EN for a 2-entry AR queue that chains bursts without an idle cycle.
module axi_read_slv #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);
  localparam int EW = ID_WIDTH + ADDR_WIDTH + 13;
  typedef enum logic [1:0] {IDLE, REQ, CAP, RESP} state_t;
  state_t r_state, w_next;
  logic [ID_WIDTH-1:0] r_id;
  logic [ADDR_WIDTH-1:0] r_addr, w_bytes, w_mask, w_next_addr;
  logic [7:0] r_len, r_cnt, w_ld_len;
  logic [2:0] r_size, w_ld_size;
  logic [1:0] r_burst, w_ld_burst;
  logic r_err, r_arok, w_ar_hs, w_r_hs, w_last, w_ld_en, w_ld_err, w_q_ne;
  logic [DATA_WIDTH-1:0] r_data;
  logic [EW-1:0] w_ar, w_head, w_ld;
  assign w_ar = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
  assign w_ar_hs = ARVALID & ARREADY;
  assign w_r_hs = RVALID & RREADY;
  assign w_last = r_cnt == r_len;
  // A queued burst takes priority; otherwise an AR arriving with the last beat is loaded directly.
  assign w_ld_en = (r_state == IDLE & w_ar_hs) | (w_r_hs & w_last & (w_q_ne | w_ar_hs));
  assign w_ld = w_q_ne ? w_head : w_ar;
  assign w_ld_len = w_ld[12:5];
  assign w_ld_size = w_ld[4:2];
  assign w_ld_burst = w_ld[1:0];
  assign w_ld_err = w_ld_burst == 2'b11 | w_ld_size > 3'd3 |
                    (w_ld_burst == 2'b10 & !(w_ld_len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  assign w_bytes = ADDR_WIDTH'(1) << r_size;
  assign w_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
  assign w_next_addr = r_burst == 2'b00 ? r_addr :
                       r_burst == 2'b10 ? (r_addr & ~w_mask) | ((r_addr + w_bytes) & w_mask) :
                       r_addr + w_bytes;
`ifdef AXI_READ_SLV_OUTSTAND_EN
  logic [EW-1:0] r_q [2];
  logic r_wp, r_rp, w_push, w_pop;
  logic [1:0] r_qn;
  assign w_q_ne = r_qn != 2'd0;
  assign w_head = r_q[r_rp];
  assign w_pop = w_r_hs & w_last & w_q_ne;
  assign w_push = w_ar_hs & ~(w_ld_en & ~w_q_ne);
  assign ARREADY = r_arok & (r_qn != 2'd2);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_q <= '{default: '0};
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_qn <= 2'd0;
    end else begin
      if (w_push) begin
        r_q[r_wp] <= w_ar;
        r_wp <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_qn <= r_qn + {1'b0, w_push} - {1'b0, w_pop};
    end
`else
  assign w_q_ne = 1'b0;
  assign w_head = '0;
  assign ARREADY = r_arok & (r_state == IDLE);
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_ar_hs ? REQ : IDLE;
      REQ: w_next = CAP;
      CAP: w_next = RESP;
      default: w_next = !w_r_hs ? RESP : (!w_last || w_ld_en) ? REQ : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_arok <= 1'b0;
      r_id <= '0;
      r_addr <= '0;
      r_len <= '0;
      r_size <= '0;
      r_burst <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_data <= '0;
    end else begin
      r_state <= w_next;
      r_arok <= 1'b1;
      if (w_ld_en) begin
        {r_id, r_addr, r_len, r_size, r_burst} <= w_ld;
        r_cnt <= '0;
        r_err <= w_ld_err;
      end else if (w_r_hs) begin
        r_addr <= w_next_addr;
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_state == CAP) r_data <= r_err ? '0 : mem_rd_data;
    end
  assign RVALID = r_state == RESP;
  assign RLAST = RVALID & w_last;
  assign RRESP = {r_err, 1'b0};
  assign RID = r_id;
  assign RDATA = r_data;
  assign mem_rd_en = r_state == REQ & ~r_err;
  assign mem_rd_addr = {r_addr[ADDR_WIDTH-1:3], 3'b000};
endmodule

// File: tb/tb_axi_read_slv.sv
// tb_axi_read_slv: randomized self-checking bench for axi_read_slv with a burst-level reference model.
module tb_axi_read_slv;
  localparam int IW = 4, AW = 10, DW = 64;
`ifdef AXI_READ_SLV_OUTSTAND_EN
  localparam bit OUTSTAND = 1'b1;
`else
  localparam bit OUTSTAND = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [IW-1:0] ARID = '0;
  logic [AW-1:0] ARADDR = '0;
  logic [7:0] ARLEN = '0;
  logic [2:0] ARSIZE = '0;
  logic [1:0] ARBURST = '0;
  logic ARVALID = 1'b0, ARREADY;
  logic [IW-1:0] RID;
  logic [DW-1:0] RDATA;
  logic [1:0] RRESP;
  logic RLAST, RVALID, RREADY = 1'b0;
  logic mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  int vecs = 0, errs = 0, cyc = 0, ar_cyc = 0;
  logic [DW-1:0] mem [128];
  typedef struct {logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} beat_t;
  beat_t exp_q[$];
  logic [AW-1:0] exp_mem[$], mem_log[$];
  int mem_cyc[$], last_hs_q[$];

  axi_read_slv #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr[9:3]] : {$urandom, $urandom};
  always @(negedge clk)
    if (rst_n && mem_rd_en) begin
      mem_log.push_back(mem_rd_addr);
      mem_cyc.push_back(cyc);
    end

  task automatic clear_logs();
    exp_q.delete();
    exp_mem.delete();
    mem_log.delete();
    mem_cyc.delete();
    last_hs_q.delete();
  endtask

  task automatic model_push(input logic [IW-1:0] id, input int a, input int len, input int sz, input int b);
    bit err;
    int bytes, total, base, ea;
    err = b == 3 || sz > 3 || (b == 2 && !(len inside {1, 3, 7, 15}));
    bytes = 1 << sz;
    total = (len + 1) * bytes;
    base = (a / total) * total;
    for (int i = 0; i <= len; i++) begin
      ea = b == 0 ? a : b == 2 ? base + ((a - base) + i * bytes) % total : (a + i * bytes) % 1024;
      exp_q.push_back('{id, err ? '0 : mem[(ea % 1024) / 8], err ? 2'b10 : 2'b00, i == len});
      if (!err) exp_mem.push_back(AW'((ea % 1024) / 8 * 8));
    end
  endtask

  task automatic issue_ar(input int id, input int a, input int len, input int sz, input int b);
    int n = 0;
    ARID = IW'(id); ARADDR = AW'(a); ARLEN = 8'(len); ARSIZE = 3'(sz); ARBURST = 2'(b);
    ARVALID = 1'b1;
    while (ARREADY !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (ARREADY !== 1'b1) begin
      errs++;
      $display("FAIL ar_accept: ARREADY=%b after %0d cycles, required 1", ARREADY, n);
    end else begin
      ar_cyc = cyc;
      model_push(IW'(id), a, len, sz, b);
    end
    @(negedge clk);
    ARVALID = 1'b0;
  endtask

  // mode 0: RREADY high; 1: hold low 5 cycles on beat stall_beat; 2: random RREADY
  task automatic drain(input int mode, input int stall_beat, input int first_cyc);
    int budget = 0, beat = 0, stall = 0, want, idle_v = 0;
    bit was_v = 0;
    want = first_cyc + 3;
    while (exp_q.size() > 0 && budget < 3000) begin
      RREADY = mode == 2 ? 1'($urandom_range(0, 1)) : (mode == 1 && beat == stall_beat && stall < 5) ? 1'b0 : 1'b1;
      if (RVALID === 1'b1) begin
        if (!was_v) begin
          vecs++;
          if (cyc !== want) begin
            errs++;
            $display("FAIL latency: RVALID rose in cycle %0d, required %0d (beat %0d)", cyc, want, beat);
          end
        end
        vecs++;
        if (RID !== exp_q[0].id || RDATA !== exp_q[0].data || RRESP !== exp_q[0].resp || RLAST !== exp_q[0].last) begin
          errs++;
          $display("FAIL beat%0d: got id=%h data=%h resp=%b last=%b, required id=%h data=%h resp=%b last=%b",
                   beat, RID, RDATA, RRESP, RLAST, exp_q[0].id, exp_q[0].data, exp_q[0].resp, exp_q[0].last);
        end
        if (RREADY) begin
          if (exp_q[0].last) last_hs_q.push_back(cyc);
          void'(exp_q.pop_front());
          beat++;
          want = cyc + 3;
          was_v = 0;
        end else begin
          was_v = 1;
          stall++;
        end
      end
      @(negedge clk);
      budget++;
    end
    RREADY = 1'b1;
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
    end
    repeat (4) begin
      if (RVALID !== 1'b0) idle_v++;
      @(negedge clk);
    end
    vecs++;
    if (idle_v != 0) begin
      errs++;
      $display("FAIL extra_beats: RVALID high %0d idle cycles, required 0", idle_v);
    end
    vecs++;
    if (mem_log.size() != exp_mem.size()) begin
      errs++;
      $display("FAIL mem_reads: %0d reads, required %0d", mem_log.size(), exp_mem.size());
    end else
      for (int i = 0; i < mem_log.size(); i++) begin
        vecs++;
        if (mem_log[i] !== exp_mem[i]) begin
          errs++;
          $display("FAIL mem_addr%0d: got %h, required %h", i, mem_log[i], exp_mem[i]);
        end
      end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({RVALID, RLAST, RRESP, RID, RDATA, mem_rd_en, mem_rd_addr, ARREADY} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: v=%b l=%b r=%b id=%h d=%h en=%b a=%h rdy=%b, required all 0",
               RVALID, RLAST, RRESP, RID, RDATA, mem_rd_en, mem_rd_addr, ARREADY);
    end
    rst_n = 1'b1;
    #1;
    vecs++;
    if (ARREADY !== 1'b0) begin
      errs++;
      $display("FAIL arready_pre_edge: got %b, required 0", ARREADY);
    end
    @(negedge clk);
    vecs++;
    if (ARREADY !== 1'b1) begin
      errs++;
      $display("FAIL arready_post_edge: got %b, required 1", ARREADY);
    end
  endtask

  task automatic test_single();
    int first;
    clear_logs();
    issue_ar(5, 'h010, 0, 3, 1);
    first = ar_cyc;
    vecs++;
    if (ARREADY !== OUTSTAND) begin
      errs++;
      $display("FAIL arready_busy: got %b, required %b", ARREADY, OUTSTAND);
    end
    drain(0, -1, first);
    vecs++;
    if (mem_log.size() != 1 || mem_log[0] !== 10'h010 || mem_cyc[0] != first + 1) begin
      errs++;
      $display("FAIL single_mem: reads=%0d, required one read of 010 in cycle %0d", mem_log.size(), first + 1);
    end
  endtask

  task automatic test_addr_seq(input int a, input int b, input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                               input logic [AW-1:0] e2, input logic [AW-1:0] e3);
    clear_logs();
    issue_ar(9, a, 3, 3, b);
    drain(0, -1, ar_cyc);
    vecs++;
    if (mem_log.size() != 4 || mem_log[0] !== e0 || mem_log[1] !== e1 || mem_log[2] !== e2 || mem_log[3] !== e3) begin
      errs++;
      $display("FAIL addr_seq_b%0d: %0d reads, required %h %h %h %h", b, mem_log.size(), e0, e1, e2, e3);
    end
    vecs++;
    if (last_hs_q.size() != 1) begin
      errs++;
      $display("FAIL rlast_count: %0d, required 1", last_hs_q.size());
    end
  endtask

  task automatic test_error();
    clear_logs();
    issue_ar(3, 'h040, 1, 3, 3);
    drain(0, -1, ar_cyc);
    vecs++;
    if (mem_log.size() != 0) begin
      errs++;
      $display("FAIL error_mem_en: %0d reads, required 0", mem_log.size());
    end
    clear_logs();
    issue_ar(4, 'h020, 2, 3, 2);
    drain(0, -1, ar_cyc);
    clear_logs();
    issue_ar(6, 'h020, 1, 5, 1);
    drain(0, -1, ar_cyc);
  endtask

  task automatic test_backpressure();
    clear_logs();
    issue_ar(7, 'h100, 2, 3, 1);
    drain(1, 1, ar_cyc);
  endtask

  task automatic test_reset_mid();
    int n = 0, bad = 0;
    clear_logs();
    issue_ar(2, 'h200, 7, 3, 1);
    while (RVALID !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    RREADY = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++;
    if (RVALID !== 1'b0 || mem_rd_en !== 1'b0 || ARREADY !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid: RVALID=%b mem_rd_en=%b ARREADY=%b, required 0 0 0", RVALID, mem_rd_en, ARREADY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (10) begin
      @(negedge clk);
      if (RVALID !== 1'b0 || mem_rd_en !== 1'b0) bad++;
    end
    vecs++;
    if (bad != 0 || ARREADY !== 1'b1) begin
      errs++;
      $display("FAIL post_reset_idle: %0d active cycles, ARREADY=%b, required 0 and 1", bad, ARREADY);
    end
    issue_ar(1, 'h0a8, 1, 3, 1);
    drain(0, -1, ar_cyc);
  endtask

  task automatic test_random();
    int b, len, sz, r;
    for (int k = 0; k < 25; k++) begin
      clear_logs();
      r = $urandom_range(0, 9);
      b = r < 2 ? 0 : r < 6 ? 1 : r < 9 ? 2 : 3;
      len = b == 2 && $urandom_range(0, 4) != 0 ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 7);
      sz = $urandom_range(0, 9) == 0 ? $urandom_range(4, 7) : $urandom_range(0, 3);
      issue_ar($urandom_range(0, 15), $urandom_range(0, 1023), len, sz, b);
      drain($urandom_range(0, 1) * 2, -1, ar_cyc);
    end
  endtask

`ifdef AXI_READ_SLV_OUTSTAND_EN
  task automatic test_back_to_back();
    int first;
    clear_logs();
    issue_ar(1, 'h300, 1, 3, 1);
    first = ar_cyc;
    issue_ar(2, 'h018, 3, 3, 2);
    issue_ar(3, 'h050, 0, 2, 0);
    vecs++;
    if (ARREADY !== 1'b0) begin
      errs++;
      $display("FAIL queue_full: ARREADY=%b, required 0", ARREADY);
    end
    drain(0, -1, first);
    vecs++;
    if (mem_cyc.size() != 7 || last_hs_q.size() != 3 || mem_cyc[2] != last_hs_q[0] + 1 || mem_cyc[6] != last_hs_q[1] + 1) begin
      errs++;
      $display("FAIL b2b_gap: reads=%0d lasts=%0d, required next read one cycle after each last beat",
               mem_cyc.size(), last_hs_q.size());
    end
    clear_logs();
    issue_ar(4, $urandom_range(0, 1023), $urandom_range(0, 3), 3, 1);
    first = ar_cyc;
    issue_ar(5, $urandom_range(0, 1023), 7, 2, 2);
    drain(2, -1, first);
  endtask
`endif

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = {$urandom, $urandom};
    test_reset();
    test_single();
    test_addr_seq('h3F8, 1, 10'h3F8, 10'h000, 10'h008, 10'h010);
    test_addr_seq('h018, 2, 10'h018, 10'h000, 10'h008, 10'h010);
    test_error();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef AXI_READ_SLV_OUTSTAND_EN
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
